// File: rtl/noc2validready_handshake_adapter.sv
// noc2validready_handshake_adapter: per-VC FIFOs turning NoC valid/avail flits into one round-robin valid/ready stream
// Ports: clk_i/rst_i clock and synchronous active-high reset; valid_i, flit_i, virtual_channel_id_i, avail_o
// form the NoC receive side; valid_o, ready_i, flit_o, virtual_channel_id_o form the output stream;
// overflow_o is a sticky flag for pushes to a full FIFO or to a nonexistent VC.
module noc2validready_handshake_adapter #(
  parameter int FlitWidth               = 64,
  parameter int NumberOfVirtualChannels = 2,
  parameter int VirtualChannelIdWidth   = 1,
  parameter int FifoDepth               = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               valid_i,
  input  logic [FlitWidth-1:0]               flit_i,
  input  logic [VirtualChannelIdWidth-1:0]   virtual_channel_id_i,
  output logic [NumberOfVirtualChannels-1:0] avail_o,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic [FlitWidth-1:0]               flit_o,
  output logic [VirtualChannelIdWidth-1:0]   virtual_channel_id_o,
  output logic                               overflow_o
);
  localparam int NV = NumberOfVirtualChannels;
  localparam int VW = VirtualChannelIdWidth;
  localparam int PW = $clog2(FifoDepth);
  localparam int CW = $clog2(FifoDepth + 1);
  logic [FlitWidth-1:0] r_mem [NV][FifoDepth];
  logic [PW-1:0] r_wptr [NV];
  logic [PW-1:0] r_rptr [NV];
  logic [CW-1:0] r_count [NV];
  logic [VW-1:0] r_last, r_sel;
  logic r_lock, r_overflow;
  logic [NV-1:0] w_full, w_nonempty, w_push_v, w_pop_v;
  logic [VW-1:0] w_rr, w_grant;
  logic w_any, w_valid, w_pop;
  always_comb begin
    for (int v = 0; v < NV; v++) begin
      w_full[v]     = r_count[v] == CW'(FifoDepth);
      w_nonempty[v] = r_count[v] != '0;
    end
  end
  // Scan offsets from farthest to nearest so the nearest non-empty VC after r_last wins.
  always_comb begin
    w_rr  = r_last;
    w_any = 1'b0;
    for (int k = NV; k >= 1; k--)
      for (int v = 0; v < NV; v++)
        if (v == (int'(r_last) + k) % NV && w_nonempty[v]) begin
          w_rr  = VW'(v);
          w_any = 1'b1;
        end
  end
  assign w_grant = r_lock ? r_sel : w_rr;
  assign w_valid = r_lock | w_any;
  assign w_pop   = w_valid & ready_i;
  always_comb begin
    flit_o = '0;
    for (int v = 0; v < NV; v++) begin
      w_push_v[v] = valid_i && virtual_channel_id_i == VW'(v) && !w_full[v];
      w_pop_v[v]  = w_pop && w_grant == VW'(v);
      if (w_grant == VW'(v)) flit_o = r_mem[v][r_rptr[v]];
    end
  end
  assign avail_o              = ~w_full & {NV{~rst_i}};
  assign valid_o              = w_valid & ~rst_i;
  assign virtual_channel_id_o = w_grant;
  assign overflow_o           = r_overflow;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int v = 0; v < NV; v++) begin
        r_wptr[v]  <= '0;
        r_rptr[v]  <= '0;
        r_count[v] <= '0;
      end
      r_lock     <= 1'b0;
      r_sel      <= '0;
      r_last     <= VW'(NV - 1);
      r_overflow <= 1'b0;
    end else begin
      for (int v = 0; v < NV; v++) begin
        if (w_push_v[v]) r_wptr[v] <= r_wptr[v] + 1'b1;
        if (w_pop_v[v]) r_rptr[v] <= r_rptr[v] + 1'b1;
        r_count[v] <= r_count[v] + CW'(w_push_v[v]) - CW'(w_pop_v[v]);
      end
      // Any valid flit not accepted by some FIFO (full or bad VC id) is an overflow.
      if (valid_i && !(|w_push_v)) r_overflow <= 1'b1;
      if (w_pop) begin
        r_lock <= 1'b0;
        r_last <= w_grant;
      end else if (w_valid) begin
        r_lock <= 1'b1;
        r_sel  <= w_grant;
      end
    end
  end
  always_ff @(posedge clk_i)
    for (int v = 0; v < NV; v++)
      if (w_push_v[v]) r_mem[v][r_wptr[v]] <= flit_i;
endmodule
